// File: rtl/wb_select_ctrl_pkg.sv
// Shared types and constants for the write-back select sequencer.
package fm_wb_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SEL_W-1:0] SRC_MEM = 3'd5;
  localparam logic [SEL_W-1:0] SRC_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT_MEM,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clear/enable counter; done_c flags the last cycle before the count reaches MEM_TIMEOUT-1.
module wb_timeout_cnt
  import fm_wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Asserted when the next increment would land on MEM_TIMEOUT-1.
  assign done_c = (count == CNT_W'(MEM_TIMEOUT - 2));

endmodule

// File: rtl/wb_select_ctrl.sv
// Write-back sequencer: drives the 6:1 source mux select and issues one register-file write.
module wb_select_ctrl
  import fm_wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RF_AW       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_src,
  input  logic [RF_AW-1:0]  req_dest,
  output logic [SEL_W-1:0]  mux_ctrl,
  input  logic [DATA_W-1:0] mux_out,
  output logic              mem_req,
  input  logic              mem_valid,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err,
  output logic              busy
);

  wb_state_t          state_q, state_d;
  logic [RF_AW-1:0]   dest_q, dest_d;
  logic [SEL_W-1:0]   mux_ctrl_d;
  logic               mem_req_d, rf_we_d, err_d;
  logic [RF_AW-1:0]   rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_d;
  logic               cnt_clr, cnt_en, tmo_done;

  wb_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .done_c(tmo_done)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    mux_ctrl_d = mux_ctrl;
    mem_req_d  = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_src <= SRC_MAX) begin
            dest_d     = req_dest;
            mux_ctrl_d = req_src;
            if (req_src == SRC_MEM) begin
              mem_req_d = 1'b1;
              cnt_clr   = 1'b1;
              state_d   = WAIT_MEM;
            end else begin
              state_d = SELECT;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SELECT: begin
        rf_wdata_d = DATA_W'(mux_out[0]);
        rf_waddr_d = dest_q;
        rf_we_d    = 1'b1;
        state_d    = WRITE;
      end
      WAIT_MEM: begin
        // Data arriving on the final cycle still wins over the timeout.
        if (mem_valid) begin
          rf_wdata_d = mux_out;
          rf_waddr_d = dest_q;
          rf_we_d    = 1'b1;
          state_d    = WRITE;
        end else if (tmo_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      mux_ctrl  <= '0;
      mem_req   <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      mux_ctrl  <= mux_ctrl_d;
      mem_req   <= mem_req_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
      err       <= err_d;
      busy      <= (state_d != IDLE);
      req_ready <= (state_d == IDLE);
    end
  end

endmodule
